demux1_16_16b: RTL and testbench
================================

Name: demux1_16_16b

Overview:
Registered 1-to-16 demultiplexer for a 16-bit data word. On each clock edge, input word Y is routed to the one output selected by the 4-bit code {Sel3,Sel2,Sel1,Sel0}. All other outputs are driven to zero. Used as a data-steering stage ahead of 16 destination registers or lanes.

Parameters:
WIDTH, 16, data width of Y and of every output x_0..x_15. The only supported value is 16; the port widths below assume it.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
Y  input  16  data word to route
Sel3  input  1  select bit 3 (MSB)
Sel2  input  1  select bit 2
Sel1  input  1  select bit 1
Sel0  input  1  select bit 0 (LSB)
x_0 .. x_15  output  16 each  demux outputs; x_k is the destination for select code k

Behaviour:
- One clock; reset is synchronous and active-high.
- Select index: k = {Sel3,Sel2,Sel1,Sel0}, unsigned 0..15.
- Outputs are registered (16 registers of 16 bits each).
- At each rising clk edge with rst=1:
  - all x_0..x_15 <= 16'h0000
  - rst has priority over Y and select.
- At each rising clk edge with rst=0:
  - x_k <= Y
  - every x_j with j != k <= 16'h0000 (one-hot destination; stale data is never held).
- Latency is exactly 1 cycle from Y/select to output. No combinational path from inputs to outputs.
- Select change:
  - the previously selected output clears to 0 on the same edge that the new output loads Y.
  - no cycle exists in which two outputs are both non-zero from routing.
- Y change with fixed select: the selected output follows Y one cycle later.
- Reset asserted mid-operation: all outputs are 0 after that edge. Normal routing resumes on the first edge with rst=0.
- Y=0: the selected output is 0, indistinguishable from unselected outputs. This is acceptable; there is no valid flag.
- Power-up before the first reset edge: output values are undefined. Benches must apply reset first.
- Select containing X/Z in simulation: all outputs are don't-care for that cycle. Synthesis treats select as a plain 4-bit index.
- No handshake, no enable, no internal state other than the output registers.

Test Plan:
- Reset: hold rst=1 for 2 edges with Y=16'hF91D and select=4'b0101 -> all x_0..x_15 = 16'h0000.
- Select 0000: rst=0, Y=16'b1111100100011101 (16'hF91D), select=4'b0000 -> after 1 edge, x_0=16'hF91D; x_1..x_15=0.
- Select 1011: Y=16'hF91D, Sel3..Sel0=1,0,1,1 -> after 1 edge, x_11=16'hF91D; x_0 clears to 0 on the same edge; all others 0.
- Select 0110 then 1111: Y=16'hF91D, select=4'b0110 -> x_6=16'hF91D, others 0. Next cycle select=4'b1111 -> x_15=16'hF91D and x_6=0.
- Exhaustive sweep: for k=0..15, drive Y=16'hA500|k and select=k. Check one cycle later that x_k equals Y, all others are 0, and exactly one output is non-zero per cycle.
- Reset mid-stream: x_9 holding 16'h1234, assert rst=1 for one edge -> all outputs 0. Deassert with select=9 -> x_9=16'h1234 one edge later.

Source files
------------

// File: rtl/demux1_16_16b.sv
// Registered 1-to-16 demultiplexer: routes 16-bit Y to output x_k, k = {Sel3..Sel0},
// and clears every other output on the same edge. One cycle latency, sync active-high reset.
module demux1_16_16b #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Y,
    input  logic             Sel3,
    input  logic             Sel2,
    input  logic             Sel1,
    input  logic             Sel0,
    output logic [WIDTH-1:0] x_0,
    output logic [WIDTH-1:0] x_1,
    output logic [WIDTH-1:0] x_2,
    output logic [WIDTH-1:0] x_3,
    output logic [WIDTH-1:0] x_4,
    output logic [WIDTH-1:0] x_5,
    output logic [WIDTH-1:0] x_6,
    output logic [WIDTH-1:0] x_7,
    output logic [WIDTH-1:0] x_8,
    output logic [WIDTH-1:0] x_9,
    output logic [WIDTH-1:0] x_10,
    output logic [WIDTH-1:0] x_11,
    output logic [WIDTH-1:0] x_12,
    output logic [WIDTH-1:0] x_13,
    output logic [WIDTH-1:0] x_14,
    output logic [WIDTH-1:0] x_15
);

    localparam int NUM_OUT = 16;

    logic [3:0]                      sel;
    logic [NUM_OUT-1:0][WIDTH-1:0]   x_d;
    logic [NUM_OUT-1:0][WIDTH-1:0]   x_q;

    assign sel = {Sel3, Sel2, Sel1, Sel0};

    // Unselected lanes load zero so stale data never survives a select change.
    always_comb begin
        x_d = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            if (sel == 4'(j)) begin
                x_d[j] = Y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
        end else begin
            x_q <= x_d;
        end
    end

    assign x_0  = x_q[0];
    assign x_1  = x_q[1];
    assign x_2  = x_q[2];
    assign x_3  = x_q[3];
    assign x_4  = x_q[4];
    assign x_5  = x_q[5];
    assign x_6  = x_q[6];
    assign x_7  = x_q[7];
    assign x_8  = x_q[8];
    assign x_9  = x_q[9];
    assign x_10 = x_q[10];
    assign x_11 = x_q[11];
    assign x_12 = x_q[12];
    assign x_13 = x_q[13];
    assign x_14 = x_q[14];
    assign x_15 = x_q[15];

endmodule

// File: tb/tb_demux1_16_16b.sv
// Directed bench for demux1_16_16b: expected output vectors are queued when inputs are
// driven and popped after the following rising edge.
module tb_demux1_16_16b;

    logic        clk;
    logic        rst;
    logic [15:0] Y;
    logic        Sel3, Sel2, Sel1, Sel0;
    logic [15:0] x_0, x_1, x_2, x_3, x_4, x_5, x_6, x_7;
    logic [15:0] x_8, x_9, x_10, x_11, x_12, x_13, x_14, x_15;

    logic [15:0][15:0] obs;
    logic [15:0][15:0] prev_exp;
    logic              prev_vld;
    logic [15:0][15:0] sb [$];

    int checks = 0;
    int passes = 0;

    demux1_16_16b #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .Y(Y),
        .Sel3(Sel3), .Sel2(Sel2), .Sel1(Sel1), .Sel0(Sel0),
        .x_0(x_0), .x_1(x_1), .x_2(x_2), .x_3(x_3),
        .x_4(x_4), .x_5(x_5), .x_6(x_6), .x_7(x_7),
        .x_8(x_8), .x_9(x_9), .x_10(x_10), .x_11(x_11),
        .x_12(x_12), .x_13(x_13), .x_14(x_14), .x_15(x_15)
    );

    assign obs = {x_15, x_14, x_13, x_12, x_11, x_10, x_9, x_8,
                  x_7, x_6, x_5, x_4, x_3, x_2, x_1, x_0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0][15:0] model(input logic r, input logic [15:0] y,
                                                input logic [3:0] s);
        logic [15:0][15:0] v;
        v = '0;
        if (!r) v[s] = y;
        return v;
    endfunction

    function automatic int nonzero_cnt(input logic [15:0][15:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) if (v[i] != 16'h0) n++;
        return n;
    endfunction

    task automatic check_vec(input string tag, input logic [15:0][15:0] o,
                             input logic [15:0][15:0] e);
        checks++;
        assert (o === e) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    task automatic check_int(input string tag, input int o, input int e);
        checks++;
        assert (o === e) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    endtask

    // Drive at negedge, confirm outputs do not move before the edge, then compare after it.
    task automatic step(input logic r, input logic [15:0] y, input logic [3:0] s,
                        input string tag);
        logic [15:0][15:0] e;
        @(negedge clk);
        rst = r;
        Y   = y;
        {Sel3, Sel2, Sel1, Sel0} = s;
        sb.push_back(model(r, y, s));
        #1;
        if (prev_vld) check_vec({tag, "_hold"}, obs, prev_exp);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_vec(tag, obs, e);
        prev_exp = e;
        prev_vld = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        Y   = 16'h0;
        {Sel3, Sel2, Sel1, Sel0} = 4'b0;
        prev_vld = 1'b0;
        prev_exp = '0;

        step(1'b1, 16'hF91D, 4'b0101, "reset0");
        step(1'b1, 16'hF91D, 4'b0101, "reset1");
        check_vec("reset_zero", obs, '0);

        step(1'b0, 16'hF91D, 4'b0000, "sel0000");
        check_vec("sel0000_x0", obs, {240'h0, 16'hF91D});
        step(1'b0, 16'hF91D, 4'b1011, "sel1011");
        check_int("sel1011_x11", int'(x_11), 32'hF91D);
        check_int("sel1011_x0clr", int'(x_0), 0);
        step(1'b0, 16'hF91D, 4'b0110, "sel0110");
        step(1'b0, 16'hF91D, 4'b1111, "sel1111");
        check_int("sel1111_x6clr", int'(x_6), 0);
        check_int("sel1111_x15", int'(x_15), 32'hF91D);

        for (int k = 0; k < 16; k++) begin
            step(1'b0, 16'hA500 | 16'(k), 4'(k), $sformatf("sweep%0d", k));
            check_int($sformatf("sweep%0d_onehot", k), nonzero_cnt(obs), 1);
        end

        step(1'b0, 16'h1234, 4'd9, "pre_rst_x9");
        check_int("pre_rst_x9_val", int'(x_9), 32'h1234);
        step(1'b1, 16'h1234, 4'd9, "mid_rst");
        check_int("mid_rst_cnt", nonzero_cnt(obs), 0);
        step(1'b0, 16'h1234, 4'd9, "post_rst_x9");
        check_int("post_rst_x9_val", int'(x_9), 32'h1234);

        step(1'b0, 16'h0000, 4'd3, "y_zero");
        step(1'b0, 16'hFFFF, 4'd12, "y_ones");

        check_int("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
